// File: rtl/rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_pkg
//   Shared types and helpers for the round-robin arbiter.
//   - state_t        : arbiter FSM state (IDLE / BUSY)
//   - onehot_to_idx  : binary index of a one-hot vector (up to OH_MAX_W bits)
// ----------------------------------------------------------------------------
package rr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned OH_MAX_W = 64;
  localparam int unsigned OH_IDX_W = 6;

  // OR of the indices of all set bits; exact for a one-hot input, 0 for all-zero.
  function automatic logic [OH_IDX_W-1:0] onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
    logic [OH_IDX_W-1:0] idx;
    idx = {OH_IDX_W{1'b0}};
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) begin
        idx = idx | OH_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// ----------------------------------------------------------------------------
// rr_select
//   Combinational rotating-priority picker: returns the first requester at or
//   after ptr_i, wrapping past N_REQ-1 back to 0.
// Ports
//   req_i     in   N_REQ  request vector
//   ptr_i     in   IDX_W  highest-priority position
//   winner_o  out  N_REQ  one-hot winner (all-zero when no request)
//   any_req_o out  1      at least one request is present
// ----------------------------------------------------------------------------
module rr_select #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             any_req_o
);

  localparam logic [2*N_REQ-1:0] ONE_W = {{(2*N_REQ-1){1'b0}}, 1'b1};

  logic [2*N_REQ-1:0] keep_s;
  logic [2*N_REQ-1:0] masked_s;
  logic [2*N_REQ-1:0] lsb_s;

  // The request vector is duplicated; in the lower copy only bits at or above
  // ptr survive, the upper copy is left whole and supplies the wrapped-around
  // candidates. The lowest set bit of the doubled vector is then the winner.
  assign keep_s    = ~((ONE_W << ptr_i) - ONE_W);
  assign masked_s  = {req_i, req_i} & keep_s;
  assign lsb_s     = masked_s & (~masked_s + ONE_W);
  assign winner_o  = lsb_s[N_REQ-1:0] | lsb_s[2*N_REQ-1:N_REQ];
  assign any_req_o = |req_i;

endmodule

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for one shared resource. A grant is held until the
//   owner signals done, drops its request, or MAX_HOLD cycles elapse
//   (MAX_HOLD = 0 disables the limit). Every grant is followed by one idle
//   cycle. All outputs come straight from flops.
// Ports
//   clk_i        in   1      clock
//   arst_n_i     in   1      asynchronous active-low reset
//   req_i        in   N_REQ  request level per requester
//   done_i       in   N_REQ  release strobe, only the owner's bit matters
//   gnt_o        out  N_REQ  one-hot grant, zero when idle
//   gnt_idx_o    out  IDX_W  owner index (zero when idle)
//   gnt_valid_o  out  1      resource owned this cycle
//   timeout_o    out  1      pulse in the cycle after a hold-limit revoke
// ----------------------------------------------------------------------------
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          done_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [$clog2(N_REQ)-1:0]  gnt_idx_o,
  output logic                      gnt_valid_o,
  output logic                      timeout_o
);

  localparam int unsigned IDX_W    = $clog2(N_REQ);
  localparam int unsigned HC_W     = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);
  localparam logic [HC_W-1:0]  HC_LIM   = HC_W'(MAX_HOLD);
  // With no limit the counter only needs to stop short of wrapping.
  localparam logic [HC_W-1:0]  HC_SAT   = (MAX_HOLD != 0) ? HC_W'(MAX_HOLD) : {HC_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t             state_q,    state_d;
  logic [IDX_W-1:0]   ptr_q,      ptr_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   gnt_q,      gnt_d;
  logic [IDX_W-1:0]   idx_q,      idx_d;
  logic               valid_q,    valid_d;
  logic               timeout_q,  timeout_d;

  logic [N_REQ-1:0]   win_s;
  logic               any_req_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               limit_s;
  logic               owner_rel_s;
  logic               release_s;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_select (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .winner_o  (win_s),
    .any_req_o (any_req_s)
  );

  assign win_idx_s   = IDX_W'(onehot_to_idx(OH_MAX_W'(win_s)));
  assign limit_s     = (MAX_HOLD != 0) && (hold_cnt_q == HC_LIM);
  // Owner-initiated release; takes precedence over the limit for timeout_o.
  assign owner_rel_s = done_i[idx_q] | ~req_i[idx_q];
  assign release_s   = owner_rel_s | limit_s;

  // FSM state register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (release_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for grant outputs, pointer and hold counter.
  always_comb begin
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          gnt_d      = win_s;
          idx_d      = win_idx_s;
          valid_d    = 1'b1;
          hold_cnt_d = HC_ONE;
        end else begin
          gnt_d      = {N_REQ{1'b0}};
          idx_d      = {IDX_W{1'b0}};
          valid_d    = 1'b0;
          hold_cnt_d = {HC_W{1'b0}};
        end
      end
      BUSY: begin
        if (release_s) begin
          gnt_d      = {N_REQ{1'b0}};
          idx_d      = {IDX_W{1'b0}};
          valid_d    = 1'b0;
          hold_cnt_d = {HC_W{1'b0}};
          timeout_d  = limit_s & ~owner_rel_s;
          if (idx_q == LAST_IDX) begin
            ptr_d = {IDX_W{1'b0}};
          end else begin
            ptr_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          if (hold_cnt_q != HC_SAT) begin
            hold_cnt_d = hold_cnt_q + HC_ONE;
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
      end
      default: begin
        gnt_d      = {N_REQ{1'b0}};
        idx_d      = {IDX_W{1'b0}};
        valid_d    = 1'b0;
        hold_cnt_d = {HC_W{1'b0}};
      end
    endcase
  end

  // Output, pointer and hold-counter registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      gnt_q      <= {N_REQ{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= {IDX_W{1'b0}};
      hold_cnt_q <= {HC_W{1'b0}};
    end else begin
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Outputs are direct flop copies.
  always_comb begin
    gnt_o       = gnt_q;
    gnt_idx_o   = idx_q;
    gnt_valid_o = valid_q;
    timeout_o   = timeout_q;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter
//   Directed bench for rr_arbiter (N_REQ=8, MAX_HOLD=16). A queue-free
//   behavioural model tracks owner / pointer / hold age in plain integers and
//   is compared with the DUT on every falling edge; literal checks at key
//   points pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int N  = 8;
  localparam int MH = 16;

  logic         clk_i = 1'b0;
  logic         arst_n_i;
  logic [N-1:0] req_i;
  logic [N-1:0] done_i;
  logic [N-1:0] gnt_o;
  logic [2:0]   gnt_idx_o;
  logic         gnt_valid_o;
  logic         timeout_o;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found walking p, p+1, ... with wrap; -1 if none.
  function automatic int find_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model state.
  bit m_busy;
  bit m_timeout;
  int m_owner;
  int m_ptr;
  int m_age;

  // Reference model: one grant at a time, age counts cycles owned.
  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      m_busy    <= 1'b0;
      m_timeout <= 1'b0;
      m_owner   <= 0;
      m_ptr     <= 0;
      m_age     <= 0;
    end else if (!m_busy) begin
      m_timeout <= 1'b0;
      if (find_winner(req_i, m_ptr) >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= find_winner(req_i, m_ptr);
        m_age   <= 1;
      end
    end else if (done_i[m_owner] || !req_i[m_owner] || (MH != 0 && m_age >= MH)) begin
      m_busy    <= 1'b0;
      m_ptr     <= (m_owner + 1) % N;
      m_timeout <= (MH != 0 && m_age >= MH) && !done_i[m_owner] && req_i[m_owner];
      m_age     <= 0;
    end else begin
      m_age     <= m_age + 1;
      m_timeout <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    chk("model_gnt",     32'(gnt_o),       m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("model_valid",   32'(gnt_valid_o), 32'(m_busy));
    chk("model_idx",     32'(gnt_idx_o),   m_busy ? 32'(m_owner) : 32'd0);
    chk("model_timeout", 32'(timeout_o),   32'(m_timeout));
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    arst_n_i = 1'b0;
    tick();
    tick();
    arst_n_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    req_i  = 8'h00;
    done_i = 8'h00;
    do_reset();
    chk("rst_gnt",     32'(gnt_o),       32'h0);
    chk("rst_valid",   32'(gnt_valid_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o),   32'h0);

    // No requests: stays idle.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_gnt", 32'(gnt_o) | 32'(gnt_valid_o) | 32'(timeout_o), 32'h0);
    end

    // Two requesters from ptr=0, then done from owner 2.
    req_i = 8'h24;
    tick();
    chk("first_gnt", 32'(gnt_o),     32'h04);
    chk("first_idx", 32'(gnt_idx_o), 32'd2);
    tick();
    done_i = 8'h04;
    tick();
    done_i = 8'h00;
    chk("gap_gnt", 32'(gnt_o), 32'h00);
    tick();
    chk("second_gnt", 32'(gnt_o),     32'h20);
    chk("second_idx", 32'(gnt_idx_o), 32'd5);
    req_i = 8'h00;
    tick();
    chk("drop_gnt", 32'(gnt_o), 32'h00);

    // All requesting, each owner releases after two cycles: 0..7 then 0.
    do_reset();
    req_i = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rr_idx", 32'(gnt_idx_o), 32'(k % 8));
      chk("rr_gnt", 32'(gnt_o),     32'd1 << (k % 8));
      tick();
      done_i = 8'(1 << (k % 8));
      tick();
      done_i = 8'h00;
      chk("rr_gap", 32'(gnt_o), 32'h00);
    end

    // Owner 3 never releases (ptr is 1 here): revoked after 16 cycles.
    req_i = 8'h08;
    tick();
    chk("hold_idx", 32'(gnt_idx_o), 32'd3);
    repeat (15) tick();
    chk("hold_valid16", 32'(gnt_valid_o), 32'h1);
    tick();
    chk("to_gnt",   32'(gnt_o),     32'h00);
    chk("to_pulse", 32'(timeout_o), 32'h1);
    req_i = 8'h18;
    tick();
    chk("to_ptr4",  32'(gnt_idx_o), 32'd4);
    chk("to_clear", 32'(timeout_o), 32'h0);

    // Owner 4 dropped by request removal; owner 5 done at the hold limit.
    req_i = 8'h20;
    tick();
    chk("rqdrop_gnt", 32'(gnt_o), 32'h00);
    tick();
    chk("lim_idx", 32'(gnt_idx_o), 32'd5);
    repeat (15) tick();
    done_i = 8'h20;
    tick();
    done_i = 8'h00;
    chk("lim_gnt",     32'(gnt_o),     32'h00);
    chk("lim_nopulse", 32'(timeout_o), 32'h0);
    req_i = 8'h00;
    tick();

    // Reset while owner 5 holds the grant (ptr=6 wraps to 5).
    req_i = 8'h20;
    tick();
    chk("pre_rst_idx", 32'(gnt_idx_o), 32'd5);
    tick();
    #2;
    arst_n_i = 1'b0;
    #1;
    chk("async_gnt",   32'(gnt_o),       32'h00);
    chk("async_valid", 32'(gnt_valid_o), 32'h0);
    req_i = 8'hA0;
    tick();
    arst_n_i = 1'b1;
    tick();
    chk("post_rst_idx", 32'(gnt_idx_o), 32'd5);
    chk("post_rst_gnt", 32'(gnt_o),     32'h20);
    req_i = 8'h00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
